// File: rtl/bsg_runtime_timer_snoop.sv
// bsg_runtime_timer_snoop
//   Multi-channel runtime timer that passively watches the host-bound request
//   stream. A handshaken packet carrying the magic tag is a timer command:
//   opcode selects TOGGLE/START/STOP/CLEAR, channel-id selects the timer.
//   Each channel counts cycles while running and reports every completed
//   interval through a one-cycle done pulse.
//
//   Optional feature macro: BSG_RUNTIME_TIMER_SATURATE_EN
//     defined   : counters saturate at all-ones, overflow_o is a sticky flag
//     undefined : counters wrap, overflow_o is tied to 0
//
// Ports
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   v_i, ready_i       snooped handshake
//   packet_i           snooped request packet
//   running_o          per-channel running flag
//   count_o            per-channel cycle counts, channel 0 at LSB
//   laps_o             per-channel completed-interval counts
//   done_v_o           pulse: an interval completed (with done_chan_o/done_count_o)
//   err_v_o            pulse: command addressed a channel that does not exist
//   overflow_o         per-channel sticky saturation flags
module bsg_runtime_timer_snoop #(
    parameter int                     packet_width_p   = 128,
    parameter int                     tag_offset_p     = 82,
    parameter int                     tag_width_p      = 12,
    parameter logic [tag_width_p-1:0] tag_value_p      = 12'hAED,
    parameter int                     op_offset_p      = 0,
    parameter int                     chan_offset_p    = 2,
    parameter int                     num_channels_p   = 4,
    parameter int                     count_width_p    = 64,
    parameter int                     lap_width_p      = 16,
    parameter bit                     clear_on_start_p = 1'b1,
    localparam int                    chan_width_lp    = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    v_i,
    input  logic                                    ready_i,
    input  logic [packet_width_p-1:0]               packet_i,
    output logic [num_channels_p-1:0]               running_o,
    output logic [num_channels_p*count_width_p-1:0] count_o,
    output logic [num_channels_p*lap_width_p-1:0]   laps_o,
    output logic                                    done_v_o,
    output logic [chan_width_lp-1:0]                done_chan_o,
    output logic [count_width_p-1:0]                done_count_o,
    output logic                                    err_v_o,
    output logic [num_channels_p-1:0]               overflow_o
);

    localparam logic [1:0] OP_TOGGLE = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_STOP   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    logic [tag_width_p-1:0]   tag;
    logic [1:0]               op;
    logic [chan_width_lp-1:0] ch;
    logic                     fire;
    logic                     bad;
    logic                     unused;

    assign tag  = packet_i[tag_offset_p +: tag_width_p];
    assign op   = packet_i[op_offset_p +: 2];
    assign ch   = packet_i[chan_offset_p +: chan_width_lp];
    assign fire = v_i & ready_i & (tag == tag_value_p);
    // Only reachable when num_channels_p is not a power of two.
    assign bad  = fire & (32'(ch) >= 32'(num_channels_p));
    // Most packet bits are payload we never look at.
    assign unused = ^packet_i;

    logic [num_channels_p-1:0]                    stop_all;
    logic [num_channels_p-1:0][count_width_p-1:0] cnt_next_all;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
        state_e                   state_q, state_n;
        logic [count_width_p-1:0] cnt_q, cnt_n;
        logic [lap_width_p-1:0]   laps_q;
        logic                     sel, is_run, start, stop, clear;

        assign sel    = fire & (32'(ch) == 32'(c));
        assign is_run = (state_q == RUN);
        // TOGGLE resolves to START from IDLE and STOP from RUN.
        assign start  = sel & ~is_run & ((op == OP_START) | (op == OP_TOGGLE));
        assign stop   = sel &  is_run & ((op == OP_STOP)  | (op == OP_TOGGLE));
        assign clear  = sel & (op == OP_CLEAR);

        always_comb begin
            state_n = state_q;
            case (state_q)
                IDLE:    if (start) state_n = RUN;
                RUN:     if (stop)  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        // A STOP edge is still a RUN edge, so the final count includes it.
        always_comb begin
            cnt_n = cnt_q;
            if (clear) begin
                cnt_n = '0;
            end else if (start) begin
                cnt_n = clear_on_start_p ? '0 : cnt_q;
            end else if (is_run) begin
`ifdef BSG_RUNTIME_TIMER_SATURATE_EN
                if (cnt_q != '1) cnt_n = cnt_q + count_width_p'(1);
`else
                cnt_n = cnt_q + count_width_p'(1);
`endif
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                laps_q  <= '0;
            end else begin
                state_q <= state_n;
                cnt_q   <= cnt_n;
                if (clear)     laps_q <= '0;
                else if (stop) laps_q <= laps_q + lap_width_p'(1);
            end
        end

`ifdef BSG_RUNTIME_TIMER_SATURATE_EN
        logic ovf_q;
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)                  ovf_q <= 1'b0;
            else if (clear)                  ovf_q <= 1'b0;
            else if (is_run && cnt_q == '1)  ovf_q <= 1'b1;
        end
        assign overflow_o[c] = ovf_q;
`else
        assign overflow_o[c] = 1'b0;
`endif

        assign stop_all[c]     = stop;
        assign cnt_next_all[c] = cnt_n;
        assign running_o[c]    = is_run;
        assign count_o[c*count_width_p +: count_width_p] = cnt_q;
        assign laps_o[c*lap_width_p +: lap_width_p]      = laps_q;
    end

    // At most one channel stops per cycle, so an OR-mux picks its count.
    logic [count_width_p-1:0] stop_cnt;
    always_comb begin
        stop_cnt = '0;
        for (int i = 0; i < num_channels_p; i++) begin
            if (stop_all[i]) stop_cnt = stop_cnt | cnt_next_all[i];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            done_v_o     <= 1'b0;
            done_chan_o  <= '0;
            done_count_o <= '0;
            err_v_o      <= 1'b0;
        end else begin
            done_v_o <= |stop_all;
            err_v_o  <= bad;
            if (|stop_all) begin
                done_chan_o  <= ch;
                done_count_o <= stop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_bsg_runtime_timer_snoop.sv
module tb_bsg_runtime_timer_snoop;

`ifdef BSG_RUNTIME_TIMER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v, ready;
    logic [127:0] packet;

    always #5 clk = ~clk;

    // DUT A: default configuration (4 channels, 64-bit, clear on start)
    logic [3:0]   a_running, a_overflow;
    logic [255:0] a_count;
    logic [63:0]  a_laps;
    logic         a_done_v, a_err_v;
    logic [1:0]   a_done_chan;
    logic [63:0]  a_done_count;

    bsg_runtime_timer_snoop dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ready_i(ready), .packet_i(packet),
        .running_o(a_running), .count_o(a_count), .laps_o(a_laps),
        .done_v_o(a_done_v), .done_chan_o(a_done_chan), .done_count_o(a_done_count),
        .err_v_o(a_err_v), .overflow_o(a_overflow)
    );

    // DUT B: 3 channels (channel 3 is illegal), 6-bit counts, accumulating
    logic [2:0]   b_running, b_overflow;
    logic [17:0]  b_count;
    logic [47:0]  b_laps;
    logic         b_done_v, b_err_v;
    logic [1:0]   b_done_chan;
    logic [5:0]   b_done_count;

    bsg_runtime_timer_snoop #(.num_channels_p(3), .count_width_p(6), .clear_on_start_p(1'b0)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ready_i(ready), .packet_i(packet),
        .running_o(b_running), .count_o(b_count), .laps_o(b_laps),
        .done_v_o(b_done_v), .done_chan_o(b_done_chan), .done_count_o(b_done_count),
        .err_v_o(b_err_v), .overflow_o(b_overflow)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference model: each channel is described by an anchor (value at the
    // anchor edge, edge index of the anchor) and the count is derived as
    // anchor value plus elapsed edges, then wrapped or clamped.
    int              nch [2] = '{4, 3};
    int              cw  [2] = '{64, 6};
    bit              cos [2] = '{1'b1, 1'b0};
    bit              m_run  [2][4];
    longint unsigned m_base [2][4];
    longint          m_ref  [2][4];
    bit              m_ovf  [2][4];
    int              m_laps [2][4];
    bit              m_done [2], m_err [2];
    int              m_dch  [2];
    longint unsigned m_dcnt [2];
    longint          ecount = 0;

    function automatic longint unsigned msk(int d);
        return (cw[d] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << cw[d]) - 64'd1);
    endfunction

    function automatic longint unsigned raw(int d, int c);
        return m_run[d][c] ? m_base[d][c] + longint'(ecount - m_ref[d][c]) : m_base[d][c];
    endfunction

    function automatic longint unsigned disp(int d, int c);
        longint unsigned r = raw(d, c);
        if (SAT) return (r > msk(d)) ? msk(d) : r;
        return r & msk(d);
    endfunction

    task automatic model_edge();
        bit f;
        int op, ch, eff;
        longint unsigned val;
        ecount++;
        f  = v && ready && (packet[93:82] == 12'hAED);
        op = int'(packet[1:0]);
        ch = int'(packet[3:2]);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int c = 0; c < 4; c++) begin
                    m_run[d][c] = 0; m_base[d][c] = 0; m_ref[d][c] = 0;
                    m_ovf[d][c] = 0; m_laps[d][c] = 0;
                end
                m_done[d] = 0; m_err[d] = 0; m_dch[d] = 0; m_dcnt[d] = 0;
                continue;
            end
            m_done[d] = 0;
            m_err[d]  = 0;
            for (int c = 0; c < nch[d]; c++)
                if (SAT && m_run[d][c] && raw(d, c) > msk(d)) m_ovf[d][c] = 1;
            if (f) begin
                if (ch >= nch[d]) begin
                    m_err[d] = 1;
                end else begin
                    eff = op;
                    if (op == 0) eff = m_run[d][ch] ? 2 : 1;
                    case (eff)
                        1: if (!m_run[d][ch]) begin
                            m_base[d][ch] = cos[d] ? 0 : disp(d, ch);
                            m_run[d][ch]  = 1;
                            m_ref[d][ch]  = ecount;
                        end
                        2: if (m_run[d][ch]) begin
                            val = disp(d, ch);
                            m_base[d][ch] = val;
                            m_run[d][ch]  = 0;
                            m_laps[d][ch] = (m_laps[d][ch] + 1) % 65536;
                            m_done[d] = 1; m_dch[d] = ch; m_dcnt[d] = val;
                        end
                        default: begin
                            m_base[d][ch] = 0;
                            m_ref[d][ch]  = ecount;
                            m_laps[d][ch] = 0;
                            m_ovf[d][ch]  = 0;
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] run, input logic [255:0] cnt,
                             input logic [63:0] lp, input logic [3:0] ovf, input logic dv,
                             input logic [1:0] dch, input logic [63:0] dcnt, input logic ev);
        for (int c = 0; c < nch[d]; c++) begin
            chk($sformatf("d%0d_run%0d", d, c), 64'(run[c]), 64'(m_run[d][c]));
            chk($sformatf("d%0d_cnt%0d", d, c), 64'(cnt >> (c * cw[d])) & msk(d), disp(d, c));
            chk($sformatf("d%0d_laps%0d", d, c), 64'(lp >> (c * 16)) & 64'hFFFF, 64'(m_laps[d][c]));
            chk($sformatf("d%0d_ovf%0d", d, c), 64'(ovf[c]), 64'(SAT & m_ovf[d][c]));
        end
        chk($sformatf("d%0d_done_v", d), 64'(dv), 64'(m_done[d]));
        chk($sformatf("d%0d_err_v", d), 64'(ev), 64'(m_err[d]));
        if (m_done[d]) begin
            chk($sformatf("d%0d_done_chan", d), 64'(dch), 64'(m_dch[d]));
            chk($sformatf("d%0d_done_cnt", d), dcnt, m_dcnt[d]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_dut(0, a_running, a_count, a_laps, a_overflow, a_done_v, a_done_chan, a_done_count, a_err_v);
        check_dut(1, {1'b0, b_running}, 256'(b_count), 64'(b_laps), {1'b0, b_overflow},
                  b_done_v, b_done_chan, 64'(b_done_count), b_err_v);
    endtask

    function automatic logic [127:0] mk(bit good, logic [1:0] op, logic [1:0] ch);
        logic [127:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        p[93:82] = good ? 12'hAED : (12'hAED ^ 12'($urandom_range(1, 4095)));
        p[3:2] = ch;
        p[1:0] = op;
        return p;
    endfunction

    task automatic cmd(input logic [1:0] op, input logic [1:0] ch);
        v = 1'b1; ready = 1'b1; packet = mk(1'b1, op, ch);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            v = 1'b0; ready = 1'($urandom); packet = mk(1'b1, 2'($urandom), 2'($urandom));
            step();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_run"},  64'(a_running), 64'd0);
        chk({tag, "_a_cnt"},  64'(|a_count), 64'd0);
        chk({tag, "_a_laps"}, 64'(|a_laps), 64'd0);
        chk({tag, "_a_pulse"}, 64'({a_done_v, a_err_v}), 64'd0);
        chk({tag, "_b_run"},  64'(b_running), 64'd0);
        chk({tag, "_b_cnt"},  64'(|b_count), 64'd0);
        chk({tag, "_b_pulse"}, 64'({b_done_v, b_err_v}), 64'd0);
        chk({tag, "_ovf"},    64'({a_overflow, b_overflow}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1; v = 1'b0; ready = 1'b0; packet = '0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        step(); step();
        rst_n = 1'b1;
        idle(2);

        // Basic interval: START at T, STOP 100 cycles later
        cmd(2'b01, 2'd0); idle(99); cmd(2'b10, 2'd0);
        chk("basic_done_v", 64'(a_done_v), 64'd1);
        chk("basic_done_chan", 64'(a_done_chan), 64'd0);
        chk("basic_done_cnt", a_done_count, 64'd100);
        chk("basic_laps", 64'(a_laps[15:0]), 64'd1);

        // Multi-channel overlap
        cmd(2'b11, 2'd0);
        cmd(2'b01, 2'd1); idle(4); cmd(2'b01, 2'd2); idle(44); cmd(2'b10, 2'd1);
        chk("ovl_ch1_chan", 64'(a_done_chan), 64'd1);
        chk("ovl_ch1_cnt", a_done_count, 64'd50);
        idle(29); cmd(2'b00, 2'd2);
        chk("ovl_ch2_chan", 64'(a_done_chan), 64'd2);
        chk("ovl_ch2_cnt", a_done_count, 64'd75);
        chk("ovl_ch0_cnt", a_count[63:0], 64'd0);
        chk("ovl_ch3_cnt", a_count[255:192], 64'd0);

        // Ignore rules
        cmd(2'b10, 2'd1);
        chk("ign_stop_idle_pulse", 64'(a_done_v), 64'd0);
        chk("ign_stop_idle_laps", 64'(a_laps[31:16]), 64'd1);
        cmd(2'b01, 2'd1); idle(5); cmd(2'b01, 2'd1);
        v = 1'b1; ready = 1'b1; packet = mk(1'b0, 2'b10, 2'd1); step();
        chk("ign_badtag_run", 64'(a_running[1]), 64'd1);
        v = 1'b1; ready = 1'b0; packet = mk(1'b1, 2'b10, 2'd1); step();
        chk("ign_noready_run", 64'(a_running[1]), 64'd1);
        cmd(2'b10, 2'd1);
        chk("ign_done_cnt", a_done_count, 64'd9);
        cmd(2'b01, 2'd3);
        chk("err_b_pulse", 64'(b_err_v), 64'd1);
        chk("err_a_none", 64'(a_err_v), 64'd0);
        idle(1);
        chk("err_b_single", 64'(b_err_v), 64'd0);
        cmd(2'b10, 2'd3);

        // Accumulate mode on DUT B
        cmd(2'b10, 2'd0); cmd(2'b11, 2'd0);
        cmd(2'b01, 2'd0); idle(29); cmd(2'b10, 2'd0);
        chk("acc_first", 64'(b_done_count), 64'd30);
        idle(10);
        cmd(2'b01, 2'd0); idle(19); cmd(2'b10, 2'd0);
        chk("acc_second", 64'(b_done_count), 64'd50);
        chk("acc_a_second", a_done_count, 64'd20);
        chk("acc_laps", 64'(b_laps[15:0]), 64'd2);
        cmd(2'b01, 2'd0); idle(5); cmd(2'b11, 2'd0);
        chk("clr_run_kept", 64'(b_running[0]), 64'd1);
        chk("clr_cnt_zero", 64'(b_count[5:0]), 64'd0);
        idle(1);
        chk("clr_cnt_restart", 64'(b_count[5:0]), 64'd1);
        cmd(2'b10, 2'd0);

        // Wrap / saturate on the 6-bit DUT
        cmd(2'b10, 2'd1); cmd(2'b11, 2'd1); cmd(2'b01, 2'd1); idle(70);
        chk("wrap_cnt", 64'(b_count[11:6]), SAT ? 64'd63 : 64'd6);
        chk("wrap_ovf", 64'(b_overflow[1]), 64'(SAT));
        cmd(2'b11, 2'd1);
        chk("wrap_clr_ovf", 64'(b_overflow[1]), 64'd0);
        cmd(2'b10, 2'd1);

        // Reset in the middle of an interval
        cmd(2'b01, 2'd2); idle(10);
        rst_n = 1'b0;
        #1 chk_reset_outputs("mid");
        step(); step();
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_run", 64'({a_running, b_running}), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            v      = ($urandom_range(0, 7) == 0);
            ready  = ($urandom_range(0, 3) != 0);
            packet = mk($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
